// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared bus widths and funct codes for the MIPS execute stage.
// Revision: 1.0
`default_nettype none

package ex_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int FUNCT_W    = 6;
  localparam int SHAMT_W    = 5;
  localparam int MEM_SEL_W  = 4;
  localparam int REG_ADDR_W = 5;

  localparam logic [FUNCT_W-1:0] FUNCT_SLL   = 6'h00;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL   = 6'h02;
  localparam logic [FUNCT_W-1:0] FUNCT_SRA   = 6'h03;
  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [FUNCT_W-1:0] FUNCT_ADDU  = 6'h21;
  localparam logic [FUNCT_W-1:0] FUNCT_SUBU  = 6'h23;
  localparam logic [FUNCT_W-1:0] FUNCT_AND   = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR    = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR   = 6'h26;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR   = 6'h27;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT   = 6'h2A;
  localparam logic [FUNCT_W-1:0] FUNCT_SLTU  = 6'h2B;

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_divider.sv
// ex_divider: iterative restoring divider (signed/unsigned) with sign fixup and hold-at-done.
// Revision: 1.0
`default_nettype none

module ex_divider
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic              hold_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvsr_q, dvsr_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              dvz_q, dvz_d;

  logic              w_dvnd_neg;
  logic              w_dvsr_neg;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W-1:0] w_diff;
  logic              w_ge;

  assign w_dvnd_neg = signed_i & dividend_i[DATA_W-1];
  assign w_dvsr_neg = signed_i & divisor_i[DATA_W-1];

  // Partial remainder never exceeds the divisor, so the low word of the difference is exact.
  assign w_shift = {rem_q, quo_q[DATA_W-1]};
  assign w_ge    = (w_shift >= {1'b0, dvsr_q});
  assign w_diff  = w_shift[DATA_W-1:0] - dvsr_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dvz_d   = dvz_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_BUSY;
          count_d = '0;
          quo_d   = abs_val(dividend_i, w_dvnd_neg);
          rem_d   = '0;
          dvsr_d  = abs_val(divisor_i, w_dvsr_neg);
          negq_d  = w_dvnd_neg ^ w_dvsr_neg;
          negr_d  = w_dvnd_neg;
          dvz_d   = (divisor_i == '0);
        end
      end
      S_BUSY: begin
        quo_d   = {quo_q[DATA_W-2:0], w_ge};
        rem_d   = w_ge ? w_diff : w_shift[DATA_W-1:0];
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!hold_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dvz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dvz_q   <= dvz_d;
    end
  end

  // Gated with reset so the stall drops the instant reset asserts.
  assign busy_o      = rst_n & (((state_q == S_IDLE) & start_i) | (state_q == S_BUSY));
  assign done_o      = (state_q == S_DONE);
  assign quotient_o  = dvz_q ? '1 : abs_val(quo_q, negq_q);
  assign remainder_o = abs_val(rem_q, negr_q);

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage (ALU, shifter, HI/LO, iterative divider).
// Optional multiplier enabled by defining EX_MULT_EN. Revision: 1.0
`default_nettype none

module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_next_stage,
  input  logic [FUNCT_W-1:0]    funct_in,
  input  logic [SHAMT_W-1:0]    shamt_in,
  input  logic [DATA_W-1:0]     operand_1_in,
  input  logic [DATA_W-1:0]     operand_2_in,
  input  logic                  mem_read_flag_in,
  input  logic                  mem_write_flag_in,
  input  logic                  mem_sign_ext_flag_in,
  input  logic [MEM_SEL_W-1:0]  mem_sel_in,
  input  logic [DATA_W-1:0]     mem_write_data_in,
  input  logic                  reg_write_en_in,
  input  logic [REG_ADDR_W-1:0] reg_write_addr_in,
  input  logic [ADDR_W-1:0]     current_pc_addr_in,
  output logic [DATA_W-1:0]     result_out,
  output logic                  stall_request,
  output logic                  mem_read_flag_out,
  output logic                  mem_write_flag_out,
  output logic                  mem_sign_ext_flag_out,
  output logic [MEM_SEL_W-1:0]  mem_sel_out,
  output logic [DATA_W-1:0]     mem_write_data_out,
  output logic                  reg_write_en_out,
  output logic [REG_ADDR_W-1:0] reg_write_addr_out,
  output logic [ADDR_W-1:0]     current_pc_addr_out
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic              w_div_start;
  logic              w_div_busy;
  logic              w_div_done;
  logic [DATA_W-1:0] w_div_quo;
  logic [DATA_W-1:0] w_div_rem;

  assign mem_read_flag_out     = mem_read_flag_in;
  assign mem_write_flag_out    = mem_write_flag_in;
  assign mem_sign_ext_flag_out = mem_sign_ext_flag_in;
  assign mem_sel_out           = mem_sel_in;
  assign mem_write_data_out    = mem_write_data_in;
  assign reg_write_en_out      = reg_write_en_in;
  assign reg_write_addr_out    = reg_write_addr_in;
  assign current_pc_addr_out   = current_pc_addr_in;

  assign w_div_start = (funct_in == FUNCT_DIV) || (funct_in == FUNCT_DIVU);

  ex_divider #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_divider (
    .clk         (clk),
    .rst_n       (rst),
    .start_i     (w_div_start),
    .signed_i    (funct_in == FUNCT_DIV),
    .hold_i      (stall_next_stage),
    .dividend_i  (operand_1_in),
    .divisor_i   (operand_2_in),
    .busy_o      (w_div_busy),
    .done_o      (w_div_done),
    .quotient_o  (w_div_quo),
    .remainder_o (w_div_rem)
  );

  assign stall_request = w_div_busy;

`ifdef EX_MULT_EN
  logic                w_mul_signed;
  logic [2*DATA_W-1:0] w_mul_a;
  logic [2*DATA_W-1:0] w_mul_b;
  logic [2*DATA_W-1:0] w_prod;

  // One multiplier serves both forms; signed operands are sign-extended to the full product width.
  assign w_mul_signed = (funct_in == FUNCT_MULT);
  assign w_mul_a = {{DATA_W{w_mul_signed & operand_1_in[DATA_W-1]}}, operand_1_in};
  assign w_mul_b = {{DATA_W{w_mul_signed & operand_2_in[DATA_W-1]}}, operand_2_in};
  assign w_prod  = w_mul_a * w_mul_b;
`endif

  always_comb begin
    case (funct_in)
      FUNCT_SLL:  result_out = operand_2_in << shamt_in;
      FUNCT_SRL:  result_out = operand_2_in >> shamt_in;
      FUNCT_SRA:  result_out = $unsigned($signed(operand_2_in) >>> shamt_in);
      FUNCT_ADDU: result_out = operand_1_in + operand_2_in;
      FUNCT_SUBU: result_out = operand_1_in - operand_2_in;
      FUNCT_AND:  result_out = operand_1_in & operand_2_in;
      FUNCT_OR:   result_out = operand_1_in | operand_2_in;
      FUNCT_XOR:  result_out = operand_1_in ^ operand_2_in;
      FUNCT_NOR:  result_out = ~(operand_1_in | operand_2_in);
      FUNCT_SLT:  result_out = {{(DATA_W-1){1'b0}}, $signed(operand_1_in) < $signed(operand_2_in)};
      FUNCT_SLTU: result_out = {{(DATA_W-1){1'b0}}, operand_1_in < operand_2_in};
      FUNCT_MFHI: result_out = hi_q;
      FUNCT_MFLO: result_out = lo_q;
      default:    result_out = '0;
    endcase
  end

  // HI/LO only change when the instruction actually leaves EX, so a held instruction is idempotent.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!stall_next_stage) begin
      if (w_div_done) begin
        hi_d = w_div_rem;
        lo_d = w_div_quo;
      end else begin
        case (funct_in)
          FUNCT_MTHI: hi_d = operand_1_in;
          FUNCT_MTLO: lo_d = operand_1_in;
`ifdef EX_MULT_EN
          FUNCT_MULT, FUNCT_MULTU: begin
            hi_d = w_prod[2*DATA_W-1:DATA_W];
            lo_d = w_prod[DATA_W-1:0];
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed checks of ex_stage against a behavioural model.
// Revision: 1.0
`default_nettype none

module tb_ex_stage;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_next_stage;
  logic [5:0]  funct_in;
  logic [4:0]  shamt_in;
  logic [31:0] operand_1_in, operand_2_in;
  logic        mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] mem_write_data_in;
  logic        reg_write_en_in;
  logic [4:0]  reg_write_addr_in;
  logic [31:0] current_pc_addr_in;
  logic [31:0] result_out;
  logic        stall_request;
  logic        mem_read_flag_out, mem_write_flag_out, mem_sign_ext_flag_out;
  logic [3:0]  mem_sel_out;
  logic [31:0] mem_write_data_out;
  logic        reg_write_en_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] current_pc_addr_out;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk                   (clk),
    .rst                   (rst),
    .stall_next_stage      (stall_next_stage),
    .funct_in              (funct_in),
    .shamt_in              (shamt_in),
    .operand_1_in          (operand_1_in),
    .operand_2_in          (operand_2_in),
    .mem_read_flag_in      (mem_read_flag_in),
    .mem_write_flag_in     (mem_write_flag_in),
    .mem_sign_ext_flag_in  (mem_sign_ext_flag_in),
    .mem_sel_in            (mem_sel_in),
    .mem_write_data_in     (mem_write_data_in),
    .reg_write_en_in       (reg_write_en_in),
    .reg_write_addr_in     (reg_write_addr_in),
    .current_pc_addr_in    (current_pc_addr_in),
    .result_out            (result_out),
    .stall_request         (stall_request),
    .mem_read_flag_out     (mem_read_flag_out),
    .mem_write_flag_out    (mem_write_flag_out),
    .mem_sign_ext_flag_out (mem_sign_ext_flag_out),
    .mem_sel_out           (mem_sel_out),
    .mem_write_data_out    (mem_write_data_out),
    .reg_write_en_out      (reg_write_en_out),
    .reg_write_addr_out    (reg_write_addr_out),
    .current_pc_addr_out   (current_pc_addr_out)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Shifts expressed as multiply/divide by powers of two; SRA via complement identity.
  function automatic logic [31:0] ref_result(input logic [5:0] f, input logic [4:0] sh,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p2;
    longint      sa, sb;
    p2 = 32'd1 << sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      F_SLL:  return b * p2;
      F_SRL:  return b / p2;
      F_SRA:  return b[31] ? ~((~b) / p2) : (b / p2);
      F_ADDU: return a + b;
      F_SUBU: return a + (~b) + 32'd1;
      F_AND:  return a & b;
      F_OR:   return a | b;
      F_XOR:  return a ^ b;
      F_NOR:  return ~(a | b);
      F_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      F_SLTU: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      F_MFHI: return m_hi;
      F_MFLO: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_commit(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef EX_MULT_EN
    logic [63:0] prod;
`endif
    if (f == F_MTHI) m_hi = a;
    if (f == F_MTLO) m_lo = a;
`ifdef EX_MULT_EN
    if (f == F_MULT || f == F_MULTU) begin
      if (f == F_MULT) prod = 64'(longint'($signed(a)) * longint'($signed(b)));
      else             prod = 64'(longint'(a) * longint'(b));
      m_hi = prod[63:32];
      m_lo = prod[31:0];
    end
`else
    if (b == 32'hDEAD_BEEF) m_hi = m_hi;
`endif
  endfunction

  function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Caller is positioned just after a rising edge; returns just after the next one.
  task automatic apply_op(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] a,
                          input logic [31:0] b, input logic sn, output logic [31:0] got);
    logic [31:0] exp;
    funct_in = f; shamt_in = sh; operand_1_in = a; operand_2_in = b; stall_next_stage = sn;
    mem_read_flag_in = 1'($urandom); mem_write_flag_in = 1'($urandom);
    mem_sign_ext_flag_in = 1'($urandom); mem_sel_in = 4'($urandom);
    mem_write_data_in = $urandom; reg_write_en_in = 1'($urandom);
    reg_write_addr_in = 5'($urandom); current_pc_addr_in = $urandom;
    exp = ref_result(f, sh, a, b);
    @(negedge clk);
    got = result_out;
    check($sformatf("result_f%02h", f), 96'(got), 96'(exp));
    check("echo", 96'({mem_read_flag_out, mem_write_flag_out, mem_sign_ext_flag_out, mem_sel_out,
                       mem_write_data_out, reg_write_en_out, reg_write_addr_out, current_pc_addr_out}),
                  96'({mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in, mem_sel_in,
                       mem_write_data_in, reg_write_en_in, reg_write_addr_in, current_pc_addr_in}));
    @(posedge clk);
    if (!sn) model_commit(f, a, b);
    #1;
  endtask

  task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold,
                        output logic [31:0] q_got, output logic [31:0] r_got);
    logic [31:0] q_exp, r_exp;
    int          cnt;
    ref_div(s, a, b, q_exp, r_exp);
    funct_in = s ? F_DIV : F_DIVU;
    operand_1_in = a; operand_2_in = b;
    stall_next_stage = 1'($urandom);
    @(negedge clk);
    check("div_result_zero", 96'(result_out), 96'd0);
    cnt = 0;
    while (stall_request && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("div_stall_cycles", 96'(cnt), 96'd33);
    stall_next_stage = (hold > 0);
    for (int k = 0; k < hold; k++) begin
      funct_in = F_MFHI; #1;
      check("held_hi", 96'(result_out), 96'(m_hi));
      funct_in = F_MFLO; #1;
      check("held_lo", 96'(result_out), 96'(m_lo));
      funct_in = s ? F_DIV : F_DIVU; #1;
      check("held_stall", 96'(stall_request), 96'd0);
      @(negedge clk);
    end
    stall_next_stage = 1'b0;
    @(posedge clk);
    m_hi = r_exp;
    m_lo = q_exp;
    #1;
    apply_op(F_MFLO, 5'd0, 32'd0, 32'd0, 1'b0, q_got);
    apply_op(F_MFHI, 5'd0, 32'd0, 32'd0, 1'b0, r_got);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got, q, r, saved_hi, saved_lo;
    logic [5:0]  ops [16];
    ops = '{F_SLL, F_SRL, F_SRA, F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT,
            F_SLTU, F_MFHI, F_MFLO, F_MTHI, F_MTLO, 6'h3F};

    rst = 1'b0; stall_next_stage = 1'b0; funct_in = F_DIV; shamt_in = '0;
    operand_1_in = 32'd9; operand_2_in = 32'd3;
    mem_read_flag_in = 0; mem_write_flag_in = 0; mem_sign_ext_flag_in = 0; mem_sel_in = '0;
    mem_write_data_in = '0; reg_write_en_in = 0; reg_write_addr_in = '0; current_pc_addr_in = '0;
    #3;
    check("reset_stall", 96'(stall_request), 96'd0);
    funct_in = F_MFHI; #1;
    check("reset_hi", 96'(result_out), 96'd0);
    funct_in = F_MFLO; #1;
    check("reset_lo", 96'(result_out), 96'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    apply_op(F_SUBU, 5'd0, 32'd5, 32'd7, 1'b0, got);
    check("subu_const", 96'(got), 96'h0FFFF_FFFE);
    apply_op(F_SLT, 5'd0, 32'd5, 32'd7, 1'b0, got);
    check("slt_const", 96'(got), 96'd1);
    apply_op(F_SLTU, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, got);
    check("sltu_const", 96'(got), 96'd0);
    apply_op(F_SRA, 5'd4, 32'd0, 32'h8000_0000, 1'b0, got);
    check("sra_const", 96'(got), 96'h0F800_0000);
    apply_op(F_SLL, 5'd0, 32'd0, 32'hA5A5_0F0F, 1'b0, got);
    check("sll_zero", 96'(got), 96'h0A5A5_0F0F);
    apply_op(F_MTHI, 5'd0, 32'h1234_5678, 32'd0, 1'b0, got);
    apply_op(F_MFHI, 5'd0, 32'd0, 32'd0, 1'b0, got);
    check("mthi_mfhi", 96'(got), 96'h01234_5678);
    apply_op(F_MTLO, 5'd0, 32'h0BAD_CAFE, 32'd0, 1'b1, got);
    apply_op(F_MTLO, 5'd0, 32'h0BAD_CAFE, 32'd0, 1'b1, got);
    apply_op(F_MFLO, 5'd0, 32'd0, 32'd0, 1'b0, got);
    check("mtlo_held", 96'(got), 96'd0);

    saved_hi = m_hi; saved_lo = m_lo;
    apply_op(F_MULT, 5'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, got);
    check("mult_result", 96'(got), 96'd0);
    apply_op(F_MFHI, 5'd0, 32'd0, 32'd0, 1'b0, q);
    apply_op(F_MFLO, 5'd0, 32'd0, 32'd0, 1'b0, r);
`ifdef EX_MULT_EN
    check("mult_hi", 96'(q), 96'h0FFFF_FFFF);
    check("mult_lo", 96'(r), 96'h0FFFF_FFFE);
`else
    check("mult_hi_kept", 96'(q), 96'(saved_hi));
    check("mult_lo_kept", 96'(r), 96'(saved_lo));
`endif

    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, q, r);
    check("div_m7_2_lo", 96'(q), 96'h0FFFF_FFFD);
    check("div_m7_2_hi", 96'(r), 96'h0FFFF_FFFF);
    do_div(1'b0, 32'd7, 32'd0, 0, q, r);
    check("divu_by0_lo", 96'(q), 96'h0FFFF_FFFF);
    check("divu_by0_hi", 96'(r), 96'd7);
    do_div(1'b0, 32'd100, 32'd7, 3, q, r);
    check("divu_held_lo", 96'(q), 96'd14);
    check("divu_held_hi", 96'(r), 96'd2);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, q, r);
    check("div_ovf_lo", 96'(q), 96'h08000_0000);
    check("div_ovf_hi", 96'(r), 96'd0);
    do_div(1'b1, 32'hFFFF_FF00, 32'd0, 0, q, r);
    check("div_by0_signed_hi", 96'(r), 96'h0FFFF_FF00);

    for (int i = 0; i < 6; i++) begin
      do_div(1'($urandom), $urandom, (i < 3) ? 32'($urandom_range(1, 300)) : $urandom,
             int'($urandom_range(0, 2)), q, r);
    end

    for (int i = 0; i < 300; i++) begin
      apply_op(ops[$urandom_range(0, 15)], 5'($urandom), $urandom, $urandom,
               ($urandom_range(0, 3) == 0), got);
    end
    apply_op(F_MULTU, 5'd0, $urandom, $urandom, 1'b0, got);
    apply_op(F_MFHI, 5'd0, 32'd0, 32'd0, 1'b0, got);
    apply_op(F_MFLO, 5'd0, 32'd0, 32'd0, 1'b0, got);

    // Reset in the middle of a divide.
    funct_in = F_DIV; operand_1_in = 32'd1000; operand_2_in = 32'd3; stall_next_stage = 1'b0;
    @(negedge clk);
    check("div_start_stall", 96'(stall_request), 96'd1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rst_mid_stall", 96'(stall_request), 96'd0);
    funct_in = F_MTLO; operand_1_in = 32'h5555_AAAA;
    @(posedge clk); #1;
    funct_in = F_MFHI; #1;
    check("rst_mid_hi", 96'(result_out), 96'd0);
    funct_in = F_MFLO; #1;
    check("rst_mid_lo", 96'(result_out), 96'd0);
    m_hi = '0; m_lo = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    apply_op(F_MFLO, 5'd0, 32'd0, 32'd0, 1'b0, got);
    check("after_rst_stall", 96'(stall_request), 96'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
